// File: rtl/div_sched_pkg.sv
// Shared types and constants for the divider scheduler: FSM states, operand
// widths, the order in which operand words go out and results come back.
package div_sched_pkg;

  localparam int DIVIDEND_W = 10;
  localparam int DIVISOR_W  = 5;
  localparam int WORD_W     = 6;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_SEND_LO, S_SEND_HI, S_SEND_DIV, S_WAIT, S_CAP_Q, S_RESP
  } state_t;

  typedef enum logic [1:0] {OP_LO = 2'd0, OP_HI = 2'd1, OP_DIV = 2'd2} op_sel_t;

  // The divider returns the remainder first, then the quotient one cycle later.
  typedef enum logic {RES_REM = 1'b0, RES_QUO = 1'b1} res_sel_t;

  function automatic logic [WORD_W-1:0] operand_word(
    input op_sel_t                 sel,
    input logic [DIVIDEND_W-1:0]   dvd,
    input logic [DIVISOR_W-1:0]    dvs
  );
    case (sel)
      OP_LO:   return {1'b0, dvd[DIVISOR_W-1:0]};
      OP_HI:   return {1'b0, dvd[DIVIDEND_W-1:DIVISOR_W]};
      default: return {1'b0, dvs};
    endcase
  endfunction

endpackage

// File: rtl/div_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found after last_grant, wrapping around.
module rr_arbiter #(
  parameter  int NREQ = 2,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_idx
);

  logic [IDW-1:0] cand;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDW'((int'(last_grant) + k) % NREQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/div_scheduler.sv
// Shares one serial divider among NREQ requesters; trivially answerable
// requests (divide-by-zero, quotient overflow) never touch the divider.
module div_scheduler
  import div_sched_pkg::*;
#(
  parameter  int NREQ    = 2,
  parameter  int TIMEOUT = 64,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ*DIVIDEND_W-1:0] req_dividend,
  input  logic [NREQ*DIVISOR_W-1:0]  req_divisor,
  output logic [NREQ-1:0]            req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [IDW-1:0]             rsp_id,
  output logic [DIVISOR_W-1:0]       rsp_quotient,
  output logic [DIVISOR_W-1:0]       rsp_remainder,
  output logic                       rsp_ovf,
  output logic                       rsp_dbz,
  output logic                       rsp_err,
  output logic                       div_start,
  output logic [WORD_W-1:0]          div_a,
  input  logic [WORD_W-1:0]          div_result,
  input  logic                       div_done
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t                  state_q, state_d;
  logic [IDW-1:0]          last_q, last_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDW-1:0]          id_q, id_d;
  logic [DIVIDEND_W-1:0]   dvd_q, dvd_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]    res_q [2];
  logic [DIVISOR_W-1:0]    res_d [2];
  logic                    ovf_q, ovf_d, dbz_q, dbz_d, err_q, err_d;
  logic [NREQ-1:0]         grant;
  logic [IDW-1:0]          grant_idx;
  logic                    unused_result_msb;

  // The quotient always fits in 5 bits once the overflow pre-check passes.
  assign unused_result_msb = div_result[WORD_W-1];

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req        (req_valid),
    .last_grant (last_q),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  assign req_ready = (state_q == S_IDLE) ? grant : '0;

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    cnt_d     = '0;
    id_d      = id_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    dbz_d     = dbz_q;
    err_d     = err_q;
    div_start = 1'b0;
    div_a     = '0;
    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          id_d   = grant_idx;
          last_d = grant_idx;
          dvd_d  = req_dividend[int'(grant_idx)*DIVIDEND_W +: DIVIDEND_W];
          dvs_d  = req_divisor[int'(grant_idx)*DIVISOR_W +: DIVISOR_W];
          dbz_d  = (dvs_d == '0);
          ovf_d  = dbz_d || (dvd_d[DIVIDEND_W-1:DIVISOR_W] >= dvs_d);
          err_d  = 1'b0;
          if (ovf_d) begin
            res_d[RES_REM] = '0;
            res_d[RES_QUO] = '0;
            state_d        = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        div_start = 1'b1;
        state_d   = S_SEND_LO;
      end
      S_SEND_LO: begin
        div_a   = operand_word(OP_LO, dvd_q, dvs_q);
        state_d = S_SEND_HI;
      end
      S_SEND_HI: begin
        div_a   = operand_word(OP_HI, dvd_q, dvs_q);
        state_d = S_SEND_DIV;
      end
      S_SEND_DIV: begin
        div_a   = operand_word(OP_DIV, dvd_q, dvs_q);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (div_done) begin
          res_d[RES_REM] = div_result[DIVISOR_W-1:0];
          state_d        = S_CAP_Q;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d          = 1'b1;
          res_d[RES_REM] = '0;
          res_d[RES_QUO] = '0;
          state_d        = S_RESP;
        end
      end
      S_CAP_Q: begin
        res_d[RES_QUO] = div_result[DIVISOR_W-1:0];
        state_d        = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response fields are forced low outside RESP so the data registers need no reset.
  assign rsp_valid     = (state_q == S_RESP);
  assign rsp_id        = rsp_valid ? id_q : '0;
  assign rsp_quotient  = rsp_valid ? res_q[RES_QUO] : '0;
  assign rsp_remainder = rsp_valid ? res_q[RES_REM] : '0;
  assign rsp_ovf       = rsp_valid & ovf_q;
  assign rsp_dbz       = rsp_valid & dbz_q;
  assign rsp_err       = rsp_valid & err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      last_q  <= IDW'(NREQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
    id_q  <= id_d;
    dvd_q <= dvd_d;
    dvs_q <= dvs_d;
    res_q <= res_d;
    ovf_q <= ovf_d;
    dbz_q <= dbz_d;
    err_q <= err_d;
  end

endmodule

// File: tb/tb_div_scheduler.sv
// Bench for div_scheduler: behavioural divider on the div_* port and an
// arithmetic reference for responses, grants and cycle timing.
module tb_div_scheduler;

  localparam int NREQ = 2;
  localparam int TO   = 64;
  localparam int IDW  = $clog2(NREQ);
  localparam int RW   = IDW + 13;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*10-1:0]   req_dividend;
  logic [NREQ*5-1:0]    req_divisor;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid, rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic [4:0]           rsp_quotient, rsp_remainder;
  logic                 rsp_ovf, rsp_dbz, rsp_err;
  logic                 div_start, div_done;
  logic [5:0]           div_a, div_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_last = NREQ - 1;

  int   dm_phase = 0, dm_wcnt = 0, dm_lat = 0, start_cnt = 0, start_cyc = -1;
  int   dm_dd = 0, dm_ds = 1;
  bit   never_done = 1'b0;
  logic [5:0] dm_ops [3];

  div_scheduler #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_dividend  (req_dividend),
    .req_divisor   (req_divisor),
    .req_ready     (req_ready),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_quotient  (rsp_quotient),
    .rsp_remainder (rsp_remainder),
    .rsp_ovf       (rsp_ovf),
    .rsp_dbz       (rsp_dbz),
    .rsp_err       (rsp_err),
    .div_start     (div_start),
    .div_a         (div_a),
    .div_result    (div_result),
    .div_done      (div_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Divider model: collects three operand words after div_start, waits dm_lat
  // WAIT cycles, then gives remainder (with done) and quotient on the next cycle.
  always @(negedge clk) begin
    div_done   = 1'b0;
    div_result = 6'($urandom);
    if (rst) begin
      dm_phase = 0;
    end else if (div_start) begin
      dm_phase  = 1;
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
    end else if (dm_phase >= 1 && dm_phase <= 3) begin
      dm_ops[dm_phase-1] = div_a;
      dm_phase = dm_phase + 1;
      dm_wcnt  = dm_lat;
    end else if (dm_phase == 4 && !never_done) begin
      if (dm_wcnt == 0) begin
        dm_dd = int'(dm_ops[1][4:0]) * 32 + int'(dm_ops[0][4:0]);
        dm_ds = (dm_ops[2][4:0] == 5'd0) ? 1 : int'(dm_ops[2][4:0]);
        div_done   = 1'b1;
        div_result = {1'($urandom), 5'(dm_dd % dm_ds)};
        dm_phase   = 5;
      end else begin
        dm_wcnt = dm_wcnt - 1;
      end
    end else if (dm_phase == 5) begin
      div_result = {1'($urandom), 5'(dm_dd / dm_ds)};
      dm_phase   = 0;
    end
  end

  function automatic int rr_pick(input logic [NREQ-1:0] mask, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (mask[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [RW-1:0] ref_rsp(input int id, input int dvd, input int dvs);
    if (dvs == 0)        return {IDW'(id), 10'd0, 3'b110};
    if (dvd >= 32 * dvs) return {IDW'(id), 10'd0, 3'b100};
    return {IDW'(id), 5'(dvd / dvs), 5'(dvd % dvs), 3'b000};
  endfunction

  function automatic logic [RW-1:0] obs_rsp();
    return {rsp_id, rsp_quotient, rsp_remainder, rsp_ovf, rsp_dbz, rsp_err};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int rc);
    rc = -1;
    for (int n = 0; n < 400; n++) begin
      if (rsp_valid) begin
        rc = cyc;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic issue(input int id, input int dvd, input int dvs, output int acc, output int st0);
    @(negedge clk);
    req_dividend[id*10 +: 10] = 10'(dvd);
    req_divisor[id*5 +: 5]    = 5'(dvs);
    req_valid[id]             = 1'b1;
    acc = -1;
    st0 = start_cnt;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (req_ready != '0) begin
        acc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("grant_single", 32'(req_ready), 32'(1) << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask

  task automatic finish_txn(input string tag, input int id, input int dvd, input int dvs,
                            input int acc, input int st0, input int hold, output int hs);
    int rc;
    logic [RW-1:0] snap;
    wait_rsp(rc);
    if (dvs == 0 || dvd >= 32 * dvs) begin
      chk({tag, "_lat"}, rc, acc + 1);
      chk({tag, "_nostart"}, start_cnt, st0);
    end else begin
      chk({tag, "_start"}, start_cyc, acc + 1);
      chk({tag, "_ops"}, {14'd0, dm_ops[0], dm_ops[1], dm_ops[2]},
          {14'd0, 6'(dvd % 32), 6'(dvd / 32), 6'(dvs)});
      chk({tag, "_lat"}, rc, acc + 7 + dm_lat);
    end
    chk({tag, "_rsp"}, 32'(obs_rsp()), 32'(ref_rsp(id, dvd, dvs)));
    chk({tag, "_divquiet"}, {div_start, div_a}, 0);
    snap = obs_rsp();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold"}, {rsp_valid, req_ready, obs_rsp()}, {1'b1, NREQ'(0), snap});
    end
    hs = cyc;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_last = id;
  endtask

  task automatic txn(input string tag, input int id, input int dvd, input int dvs, input int lat);
    int acc, st0, hs;
    dm_lat = lat;
    issue(id, dvd, dvs, acc, st0);
    finish_txn(tag, id, dvd, dvs, acc, st0, 0, hs);
  endtask

  initial begin
    int acc, st0, hs, prev_hs, rc, w, mask;
    int dvd [NREQ];
    int dvs [NREQ];
    rst          = 1'b1;
    req_valid    = '0;
    req_dividend = '0;
    req_divisor  = '0;
    rsp_ready    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", {rsp_valid, rsp_err, rsp_ovf, rsp_dbz, rsp_quotient, rsp_remainder,
                       rsp_id, div_start, div_a, req_ready}, 0);

    txn("d45_12", 0, 45, 12, 3);
    txn("d42_7", 1, 42, 7, 0);
    txn("d212_2", 0, 212, 2, 0);
    txn("d180_0", 1, 180, 0, 0);

    never_done = 1'b1;
    dm_lat = 0;
    issue(0, 100, 9, acc, st0);
    wait_rsp(rc);
    chk("timeout_lat", rc, acc + 5 + TO);
    chk("timeout_rsp", 32'(obs_rsp()), 32'({IDW'(0), 10'd0, 3'b001}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready  = 1'b0;
    model_last = 0;
    never_done = 1'b0;

    dm_lat = 1;
    issue(1, 300, 17, acc, st0);
    repeat (2) @(negedge clk);
    chk("sendhi_word", div_a, 300 / 32);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outs", {rsp_valid, rsp_err, rsp_ovf, rsp_dbz, rsp_quotient, rsp_remainder,
                        div_start, div_a, req_ready}, 0);
    model_last = NREQ - 1;

    @(negedge clk);
    dvd = '{45, 42};
    dvs = '{12, 7};
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*10 +: 10] = 10'(dvd[i]);
      req_divisor[i*5 +: 5]    = 5'(dvs[i]);
    end
    req_valid = '1;
    prev_hs = -1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("alt_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k > 0) chk("alt_b2b", cyc, prev_hs + 1);
      acc    = cyc;
      st0    = start_cnt;
      dm_lat = k;
      finish_txn("alt", k % 2, dvd[k % 2], dvs[k % 2], acc, st0, (k == 2) ? 5 : 0, hs);
      prev_hs = hs;
    end
    req_valid = '0;

    for (int t = 0; t < 24; t++) begin
      @(negedge clk);
      mask = 0;
      while (mask == 0) mask = int'($urandom_range(0, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        dvs[i] = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 31));
        dvd[i] = ($urandom_range(0, 3) == 0 || dvs[i] == 0) ? int'($urandom_range(0, 1023))
                                                            : int'($urandom_range(0, 32 * dvs[i] - 1));
        req_dividend[i*10 +: 10] = 10'(dvd[i]);
        req_divisor[i*5 +: 5]    = 5'(dvs[i]);
      end
      req_valid = NREQ'(mask);
      #1;
      w = rr_pick(req_valid, model_last);
      chk("rand_grant", 32'(req_ready), 32'(1) << w);
      acc    = cyc;
      st0    = start_cnt;
      dm_lat = int'($urandom_range(0, 4));
      @(negedge clk);
      req_valid = '0;
      finish_txn("rand", w, dvd[w], dvs[w], acc, st0, 0, hs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
